// File: rtl/mem_dma_pkg.sv
// Shared types and defaults for the mem_dma memory-to-memory copy engine.
// Imported by rtl/mem_dma.sv and by the testbench.
package mem_dma_pkg;

   localparam int ADDR_W_DEF = 5;
   localparam int DATA_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   // The engine owns the RAM port only while moving bytes.
   function automatic logic state_is_busy(input state_t s);
      return (s == READ) || (s == WRITE);
   endfunction

endpackage

// File: rtl/mem_dma.sv
// Single-port RAM copy engine: one byte per READ/WRITE pair, ascending addresses.
// Optional constant-fill mode is compiled in when MEM_DMA_FILL_EN is defined.
module mem_dma
   import mem_dma_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] src,
   input  logic [ADDR_W-1:0] dst,
   input  logic [ADDR_W:0]   len,
`ifdef MEM_DMA_FILL_EN
   input  logic              fill_mode,
   input  logic [DATA_W-1:0] fill_value,
`endif
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
   localparam logic [ADDR_W:0]   COUNT_ONE = (ADDR_W + 1)'(1);

   state_t              state_reg;
   state_t              state_next;
   logic [ADDR_W-1:0]   src_ptr_reg;
   logic [ADDR_W-1:0]   dst_ptr_reg;
   logic [ADDR_W:0]     count_reg;
   logic [DATA_W-1:0]   hold_reg;
`ifdef MEM_DMA_FILL_EN
   logic                fill_reg;
`endif

   logic accept;
   logic len_zero;
   logic last_beat;

   assign accept    = (state_reg == IDLE) && start;
   assign len_zero  = (len == '0);
   assign last_beat = (count_reg == COUNT_ONE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (start) begin
               if (len_zero) begin
                  state_next = DONE;
`ifdef MEM_DMA_FILL_EN
               end else if (fill_mode) begin
                  state_next = WRITE;
`endif
               end else begin
                  state_next = READ;
               end
            end
         end
         READ: begin
            state_next = WRITE;
         end
         WRITE: begin
            if (last_beat) begin
               state_next = DONE;
`ifdef MEM_DMA_FILL_EN
            end else if (fill_reg) begin
               state_next = WRITE;
`endif
            end else begin
               state_next = READ;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Operands are captured only on an accepted non-empty request, so
   // activity on src/dst/len during a transfer has no effect.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         src_ptr_reg <= '0;
         dst_ptr_reg <= '0;
         count_reg   <= '0;
         hold_reg    <= '0;
`ifdef MEM_DMA_FILL_EN
         fill_reg    <= 1'b0;
`endif
      end else begin
         case (state_reg)
            IDLE: begin
               if (accept && !len_zero) begin
                  src_ptr_reg <= src;
                  dst_ptr_reg <= dst;
                  count_reg   <= len;
`ifdef MEM_DMA_FILL_EN
                  fill_reg    <= fill_mode;
                  // Fill reuses the holding register as its constant source.
                  if (fill_mode) begin
                     hold_reg <= fill_value;
                  end
`endif
               end
            end
            READ: begin
               hold_reg <= mem_rdata;
            end
            WRITE: begin
               src_ptr_reg <= src_ptr_reg + ADDR_ONE;
               dst_ptr_reg <= dst_ptr_reg + ADDR_ONE;
               count_reg   <= count_reg - COUNT_ONE;
            end
            default: begin
            end
         endcase
      end
   end

   // Outputs decode the state register alone, so reset zeroes them at once.
   always_comb begin
      busy      = state_is_busy(state_reg);
      done      = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (state_reg)
         READ: begin
            mem_addr = src_ptr_reg;
         end
         WRITE: begin
            mem_we    = 1'b1;
            mem_addr  = dst_ptr_reg;
            mem_wdata = hold_reg;
         end
         DONE: begin
            done = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_mem_dma.sv
// Directed bench for mem_dma with a 32x8 RAM (synchronous write, combinational read)
// and a transfer-level model; define MEM_DMA_FILL_EN to also exercise fill mode.
module tb_mem_dma;
   import mem_dma_pkg::*;

   typedef struct packed {
      logic       busy;
      logic       done;
      logic       we;
      logic [4:0] addr;
      logic [7:0] wdata;
   } obs_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [4:0] src = '0;
   logic [4:0] dst = '0;
   logic [5:0] len = '0;
`ifdef MEM_DMA_FILL_EN
   logic       fill_mode = 1'b0;
   logic [7:0] fill_value = '0;
`endif
   logic       busy, done, mem_we;
   logic [4:0] mem_addr;
   logic [7:0] mem_wdata, mem_rdata;

   logic [7:0] ram [0:31];
   logic [7:0] model_mem [0:31];
   logic       poke_en = 1'b0;
   logic [4:0] poke_addr = '0;
   logic [7:0] poke_data = '0;

   obs_t exp_q[$];
   logic checking = 1'b0;
   int   n_pass = 0;
   int   n_total = 0;

   mem_dma #(.ADDR_W(5), .DATA_W(8)) dut (
      .clk(clk), .reset(reset), .start(start), .src(src), .dst(dst), .len(len),
`ifdef MEM_DMA_FILL_EN
      .fill_mode(fill_mode), .fill_value(fill_value),
`endif
      .busy(busy), .done(done), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_we(mem_we), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else if (poke_en) ram[poke_addr] <= poke_data;
   end
   assign mem_rdata = ram[mem_addr];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_total++;
      if (act === exp_v) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
   endtask

   // Per-cycle compare against the expected trace; an empty trace means idle.
   always @(negedge clk) begin : cmp
      obs_t e;
      obs_t a;
      if (checking) begin
         e = '0;
         if (exp_q.size() != 0) e = exp_q.pop_front();
         a = {busy, done, mem_we, mem_addr, mem_wdata};
         n_total++;
         if (a === e) n_pass++;
         else $display("FAIL cycle t=%0t: got busy=%b done=%b we=%b addr=%0d wdata=%h, expected busy=%b done=%b we=%b addr=%0d wdata=%h",
                       $time, a.busy, a.done, a.we, a.addr, a.wdata, e.busy, e.done, e.we, e.addr, e.wdata);
      end
   end

   task automatic push_obs(input logic b, input logic d, input logic w, input logic [4:0] ad, input logic [7:0] wd);
      obs_t o;
      o = {b, d, w, ad, wd};
      exp_q.push_back(o);
   endtask

   task automatic poke(input logic [4:0] a, input logic [7:0] d);
      @(negedge clk);
      poke_en = 1'b1; poke_addr = a; poke_data = d;
      @(posedge clk);
      #1 poke_en = 1'b0;
      model_mem[a] = d;
   endtask

   // Issue a request, then derive the whole expected trace by copying bytes
   // one at a time through the model memory.
   task automatic launch(input logic [4:0] s, input logic [4:0] d, input int l,
                         input logic fm, input logic [7:0] fv);
      logic [4:0] as;
      logic [4:0] ad;
      logic [7:0] data;
      @(negedge clk);
      src = s; dst = d; len = 6'(l); start = 1'b1;
`ifdef MEM_DMA_FILL_EN
      fill_mode = fm; fill_value = fv;
`endif
      @(posedge clk);
      #1 start = 1'b0;
      for (int i = 0; i < l; i++) begin
         as = 5'(int'(s) + i);
         ad = 5'(int'(d) + i);
         if (fm) begin
            data = fv;
         end else begin
            push_obs(1'b1, 1'b0, 1'b0, as, 8'h00);
            data = model_mem[as];
         end
         model_mem[ad] = data;
         push_obs(1'b1, 1'b0, 1'b1, ad, data);
      end
      push_obs(1'b0, 1'b1, 1'b0, 5'd0, 8'h00);
   endtask

   task automatic wait_done(output int cyc, output int bcnt, output int wcnt);
      logic found;
      found = 1'b0;
      cyc = 0; bcnt = 0; wcnt = 0;
      for (int k = 0; k < 100 && !found; k++) begin
         @(negedge clk);
         cyc++;
         bcnt += int'(busy);
         wcnt += int'(mem_we);
         if (done) found = 1'b1;
      end
      if (!found) begin
         n_total++;
         $display("FAIL done_timeout: got no done, required done within 100 cycles");
      end
   endtask

   task automatic ram_all(input string tag);
      for (int i = 0; i < 32; i++)
         chk($sformatf("%s_ram[%0d]", tag, i), 32'(ram[i]), 32'(model_mem[i]));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, required finish before 200000");
      $fatal(1, "watchdog");
   end

   initial begin
      int c, b, w;
      #1;
      chk("reset_outputs", 32'({busy, done, mem_we, mem_addr, mem_wdata}), 32'h0);
      for (int i = 0; i < 32; i++) poke(5'(i), 8'(i * 37 + 5));
      poke(5'd0, 8'h11); poke(5'd1, 8'h22); poke(5'd2, 8'h33); poke(5'd3, 8'h44);
      @(negedge clk);
      reset = 1'b0;
      checking = 1'b1;

      // Basic copy
      launch(5'd0, 5'd8, 4, 1'b0, 8'h00);
      wait_done(c, b, w);
      chk("s1_done_cycle", 32'(c), 32'd9);
      chk("s1_busy_cycles", 32'(b), 32'd8);
      chk("s1_write_cycles", 32'(w), 32'd4);
      chk("s1_ram8", 32'(ram[8]), 32'h11);
      chk("s1_ram9", 32'(ram[9]), 32'h22);
      chk("s1_ram10", 32'(ram[10]), 32'h33);
      chk("s1_ram11", 32'(ram[11]), 32'h44);
      ram_all("s1");

      // Source address wrap
      poke(5'd30, 8'hA1); poke(5'd31, 8'hA2); poke(5'd0, 8'hA3); poke(5'd1, 8'hA4);
      launch(5'd30, 5'd5, 4, 1'b0, 8'h00);
      wait_done(c, b, w);
      chk("s2_done_cycle", 32'(c), 32'd9);
      chk("s2_ram5", 32'(ram[5]), 32'hA1);
      chk("s2_ram6", 32'(ram[6]), 32'hA2);
      chk("s2_ram7", 32'(ram[7]), 32'hA3);
      chk("s2_ram8", 32'(ram[8]), 32'hA4);
      ram_all("s2");

      // Zero length
      launch(5'd3, 5'd12, 0, 1'b0, 8'h00);
      wait_done(c, b, w);
      chk("s3_done_cycle", 32'(c), 32'd1);
      chk("s3_busy_cycles", 32'(b), 32'd0);
      chk("s3_write_cycles", 32'(w), 32'd0);

      // Forward overlap with a stray start mid-transfer
      poke(5'd4, 8'h5A);
      launch(5'd4, 5'd5, 3, 1'b0, 8'h00);
      @(negedge clk);
      src = 5'd0; dst = 5'd20; len = 6'd9; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(c, b, w);
      chk("s4_ram5", 32'(ram[5]), 32'h5A);
      chk("s4_ram6", 32'(ram[6]), 32'h5A);
      chk("s4_ram7", 32'(ram[7]), 32'h5A);
      chk("s4_ram8", 32'(ram[8]), 32'hA4);
      ram_all("s4");

      // Reset during the second WRITE of a len=4 copy
      @(negedge clk);
      checking = 1'b0;
      src = 5'd0; dst = 5'd20; len = 6'd4; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      chk("s5_in_write2", 32'({mem_we, mem_addr}), 32'({1'b1, 5'd21}));
      reset = 1'b1;
      #1;
      chk("s5_abort_outputs", 32'({busy, done, mem_we, mem_addr, mem_wdata}), 32'h0);
      repeat (2) begin
         @(negedge clk);
         chk("s5_no_done_in_reset", 32'(done), 32'd0);
      end
      reset = 1'b0;
      repeat (4) begin
         @(negedge clk);
         chk("s5_no_done_after", 32'({busy, done}), 32'd0);
      end
      chk("s5_byte_written", 32'(ram[20]), 32'hA3);
      model_mem[20] = 8'hA3;
      ram_all("s5");
      exp_q.delete();
      checking = 1'b1;

`ifdef MEM_DMA_FILL_EN
      launch(5'd0, 5'd16, 16, 1'b1, 8'hFF);
      wait_done(c, b, w);
      chk("s6_done_cycle", 32'(c), 32'd17);
      chk("s6_busy_cycles", 32'(b), 32'd16);
      chk("s6_write_cycles", 32'(w), 32'd16);
      for (int i = 16; i < 32; i++) chk($sformatf("s6_ram%0d", i), 32'(ram[i]), 32'hFF);
      ram_all("s6");
      fill_mode = 1'b0;
`endif

      repeat (3) @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
